sram_master: RTL and testbench
==============================

SRAM_MASTER -- requirements
Module: sram_master

Interface
REQ-001 SHALL provide parameter WAIT_CYCLES, default 1, extra cycles each access is held beyond the first (range 0-15).
REQ-002 SHALL provide port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL provide port reset  input  1  reset, asynchronous, active-high.
REQ-004 SHALL provide port cmd_valid  input  1  command request.
REQ-005 SHALL provide port cmd_ready  output  1  block can accept a command.
REQ-006 SHALL provide port cmd_op  input  2  0=write byte, 1=read byte, 2=fill range, 3=sum range.
REQ-007 SHALL provide port cmd_addr  input  17  start address.
REQ-008 SHALL provide port cmd_len  input  17  byte count for ops 2/3; ignored for ops 0/1.
REQ-009 SHALL provide port cmd_data  input  8  write byte / fill pattern.
REQ-010 SHALL provide port rsp_valid  output  1  one-cycle completion pulse.
REQ-011 SHALL provide port rsp_data  output  16  command result.
REQ-012 SHALL provide ports m_chipselect_n, m_byteenable_n, m_write_n, m_read_n  output  1 each  active-low bus strobes to the SRAM bridge.
REQ-013 SHALL provide port m_address  output  17  bus address.
REQ-014 SHALL provide port m_writedata  output  8  bus write data.
REQ-015 SHALL provide port m_readdata  input  8  bus read data.

Function
REQ-016 SHALL implement FSM states IDLE, ACCESS, GAP, DONE.
REQ-017 SHALL drive cmd_ready=1 only in IDLE; command accepted on a rising edge with cmd_valid=1 and cmd_ready=1; operands latched at that edge.
REQ-018 SHALL, on accept, go IDLE->ACCESS, or IDLE->DONE when op is 2/3 and cmd_len=0.
REQ-019 SHALL hold ACCESS exactly WAIT_CYCLES+1 cycles with m_chipselect_n=0, m_byteenable_n=0, m_address stable, and m_write_n=0 (ops 0/2) or m_read_n=0 (ops 1/3), never both.
REQ-020 SHALL drive m_writedata=latched cmd_data throughout ACCESS of write ops.
REQ-021 SHALL sample m_readdata at the rising edge ending the last ACCESS cycle.
REQ-022 SHALL follow every ACCESS with one GAP cycle: all four strobes=1, m_address/m_writedata hold.
REQ-023 SHALL, from GAP, go to ACCESS with m_address+1 if bytes remain, else DONE.
REQ-024 SHALL advance address modulo 2^17 (0x1FFFF wraps to 0x00000).
REQ-025 SHALL hold rsp_valid=1 for exactly the one DONE cycle, then return to IDLE.
REQ-026 SHALL set rsp_data: op1={8'h00,byte read}; op3=16-bit modulo sum of all bytes read (zero-extended); ops 0/2 and len=0=16'h0000; rsp_data holds until next DONE.
REQ-027 SHALL register all m_* outputs and rsp_* outputs (no combinational path from cmd_* to m_*).
REQ-028 SHALL ignore cmd_valid outside IDLE; commands are not queued.
REQ-029 SHALL, for WAIT_CYCLES=1, give single-access latency: accept edge 0, ACCESS cycles 1-2, GAP 3, rsp_valid cycle 4, cmd_ready cycle 5.
REQ-030 SHALL take 1+N*(WAIT_CYCLES+2)+1 cycles from accept to IDLE for N-byte range ops.

Reset
REQ-031 SHALL on reset assertion immediately force: state IDLE, all four strobes=1, m_address=0, m_writedata=0, rsp_valid=0, rsp_data=0, sum and counters=0, cmd_ready=1 after release.
REQ-032 SHALL abort any in-progress command on reset with no rsp_valid pulse; first command after release behaves as from power-up.

Verification
REQ-033 Write: op0 addr 0x00010 data 0xA5, WAIT=1 -> m_write_n low cycles 1-2 addr 0x00010 data 0xA5, GAP cycle 3, rsp_valid cycle 4 rsp_data 0x0000.
REQ-034 Read: op1 addr 0x00010, model returns 0xA5 -> m_read_n low 2 cycles, rsp_data 0x00A5, m_write_n stays 1.
REQ-035 Sum wrap: op3 addr 0x1FFFE len 4, memory 0xFF each -> addresses 0x1FFFE,0x1FFFF,0x00000,0x00001; rsp_data 0x03FC; 4 GAP cycles with strobes high.
REQ-036 Fill/zero-length: op2 addr 0x100 len 3 data 0x5A -> three writes 0x100-0x102; op2 len 0 -> no strobe asserted, rsp_valid on cycle after accept.
REQ-037 Back-pressure: cmd_valid held high during busy with changing operands -> only first accepted; next accepted in cycle cmd_ready returns to 1.
REQ-038 Reset mid-op: assert reset during second ACCESS of op3 len 8 -> strobes high same cycle, no rsp_valid; after release op1 completes normally.

Source files
------------

// File: rtl/sram_master.sv
// sram_master
//   Command-driven byte master for an asynchronous-SRAM bridge. It executes
//   a single command at a time: write byte, read byte, fill a range with a
//   pattern, or sum a range of bytes. Each bus access holds the strobes for
//   WAIT_CYCLES+1 cycles. A one-cycle GAP with all strobes released follows
//   every access.
//
// Parameters
//   WAIT_CYCLES  extra cycles each access is held beyond the first (0..15)
//
// Ports
//   clk, reset                 clock; asynchronous active-high reset
//   cmd_valid / cmd_ready      command handshake (ready only while idle)
//   cmd_op                     0=write byte, 1=read byte, 2=fill, 3=sum
//   cmd_addr, cmd_len          start address; byte count for ops 2/3
//   cmd_data                   write byte / fill pattern
//   rsp_valid, rsp_data        one-cycle completion pulse and result
//   m_chipselect_n, m_byteenable_n, m_write_n, m_read_n
//                              active-low registered bus strobes
//   m_address, m_writedata     registered bus address / write data
//   m_readdata                 bus read data, sampled at the end of an access
module sram_master #(
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [16:0] cmd_addr,
    input  logic [16:0] cmd_len,
    input  logic [7:0]  cmd_data,
    output logic        rsp_valid,
    output logic [15:0] rsp_data,
    output logic        m_chipselect_n,
    output logic        m_byteenable_n,
    output logic        m_write_n,
    output logic        m_read_n,
    output logic [16:0] m_address,
    output logic [7:0]  m_writedata,
    input  logic [7:0]  m_readdata
);

    typedef enum logic [1:0] {IDLE, ACCESS, GAP, DONE} state_t;

    localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES);

    state_t      state_reg, state_next;
    logic [1:0]  op_reg, op_next;
    logic [16:0] remaining_reg, remaining_next;
    logic [3:0]  wait_cnt_reg, wait_cnt_next;
    logic [15:0] sum_reg, sum_next;
    logic [16:0] address_reg, address_next;
    logic [7:0]  writedata_reg, writedata_next;
    logic        cs_n_reg, cs_n_next;
    logic        write_n_reg, write_n_next;
    logic        read_n_reg, read_n_next;
    logic        rsp_valid_reg, rsp_valid_next;
    logic [15:0] rsp_data_reg, rsp_data_next;

    // op bit 0 selects read (ops 1/3); op bit 1 selects range ops (2/3).
    always_comb begin
        state_next     = state_reg;
        op_next        = op_reg;
        remaining_next = remaining_reg;
        wait_cnt_next  = wait_cnt_reg;
        sum_next       = sum_reg;
        address_next   = address_reg;
        writedata_next = writedata_reg;
        cs_n_next      = cs_n_reg;
        write_n_next   = write_n_reg;
        read_n_next    = read_n_reg;
        rsp_valid_next = 1'b0;
        rsp_data_next  = rsp_data_reg;

        case (state_reg)
            IDLE: begin
                if (cmd_valid) begin
                    op_next        = cmd_op;
                    address_next   = cmd_addr;
                    writedata_next = cmd_data;
                    sum_next       = 16'h0000;
                    wait_cnt_next  = 4'd0;
                    remaining_next = cmd_op[1] ? cmd_len : 17'd1;
                    if (cmd_op[1] && (cmd_len == 17'd0)) begin
                        // Empty range: complete without touching the bus.
                        state_next     = DONE;
                        rsp_valid_next = 1'b1;
                        rsp_data_next  = 16'h0000;
                    end else begin
                        // Strobes are registered, so assert them on the
                        // accept edge to have them valid in the first ACCESS cycle.
                        state_next   = ACCESS;
                        cs_n_next    = 1'b0;
                        write_n_next = cmd_op[0];
                        read_n_next  = ~cmd_op[0];
                    end
                end
            end

            ACCESS: begin
                if (wait_cnt_reg == WAIT_LAST) begin
                    // Last access cycle: read data is valid at this edge.
                    state_next     = GAP;
                    cs_n_next      = 1'b1;
                    write_n_next   = 1'b1;
                    read_n_next    = 1'b1;
                    remaining_next = remaining_reg - 17'd1;
                    if (op_reg[0]) begin
                        sum_next = sum_reg + {8'h00, m_readdata};
                    end
                end else begin
                    wait_cnt_next = wait_cnt_reg + 4'd1;
                end
            end

            GAP: begin
                if (remaining_reg != 17'd0) begin
                    // 17-bit add wraps 0x1FFFF to 0x00000 naturally.
                    state_next    = ACCESS;
                    address_next  = address_reg + 17'd1;
                    wait_cnt_next = 4'd0;
                    cs_n_next     = 1'b0;
                    write_n_next  = op_reg[0];
                    read_n_next   = ~op_reg[0];
                end else begin
                    state_next     = DONE;
                    rsp_valid_next = 1'b1;
                    // For a single read the sum is just the byte read.
                    rsp_data_next  = op_reg[0] ? sum_reg : 16'h0000;
                end
            end

            DONE: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            op_reg        <= 2'd0;
            remaining_reg <= 17'd0;
            wait_cnt_reg  <= 4'd0;
            sum_reg       <= 16'h0000;
            address_reg   <= 17'd0;
            writedata_reg <= 8'h00;
            cs_n_reg      <= 1'b1;
            write_n_reg   <= 1'b1;
            read_n_reg    <= 1'b1;
            rsp_valid_reg <= 1'b0;
            rsp_data_reg  <= 16'h0000;
        end else begin
            state_reg     <= state_next;
            op_reg        <= op_next;
            remaining_reg <= remaining_next;
            wait_cnt_reg  <= wait_cnt_next;
            sum_reg       <= sum_next;
            address_reg   <= address_next;
            writedata_reg <= writedata_next;
            cs_n_reg      <= cs_n_next;
            write_n_reg   <= write_n_next;
            read_n_reg    <= read_n_next;
            rsp_valid_reg <= rsp_valid_next;
            rsp_data_reg  <= rsp_data_next;
        end
    end

    assign cmd_ready      = (state_reg == IDLE);
    assign rsp_valid      = rsp_valid_reg;
    assign rsp_data       = rsp_data_reg;
    assign m_chipselect_n = cs_n_reg;
    assign m_byteenable_n = cs_n_reg;
    assign m_write_n      = write_n_reg;
    assign m_read_n       = read_n_reg;
    assign m_address      = address_reg;
    assign m_writedata    = writedata_reg;

endmodule

// File: tb/tb_sram_master.sv
// Testbench for sram_master. A bus-side SRAM model answers reads and
// captures writes. The driver keeps its own reference memory. Each command
// pushes its expected bus accesses and response into queues, and a monitor
// pops those entries and compares them against what the DUT produces.
module tb_sram_master;

    localparam int W = 1;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [16:0] cmd_addr;
    logic [16:0] cmd_len;
    logic [7:0]  cmd_data;
    logic        rsp_valid;
    logic [15:0] rsp_data;
    logic        m_chipselect_n, m_byteenable_n, m_write_n, m_read_n;
    logic [16:0] m_address;
    logic [7:0]  m_writedata;
    logic [7:0]  m_readdata;

    sram_master #(.WAIT_CYCLES(W)) dut (
        .clk            (clk),
        .reset          (reset),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_op         (cmd_op),
        .cmd_addr       (cmd_addr),
        .cmd_len        (cmd_len),
        .cmd_data       (cmd_data),
        .rsp_valid      (rsp_valid),
        .rsp_data       (rsp_data),
        .m_chipselect_n (m_chipselect_n),
        .m_byteenable_n (m_byteenable_n),
        .m_write_n      (m_write_n),
        .m_read_n       (m_read_n),
        .m_address      (m_address),
        .m_writedata    (m_writedata),
        .m_readdata     (m_readdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Bus-side SRAM model (written only by the DUT) and bench reference memory.
    logic [7:0] mem     [0:131071];
    logic [7:0] ref_mem [0:131071];

    assign m_readdata = mem[m_address];
    always @(posedge clk) begin
        if (!reset && !m_chipselect_n && !m_write_n) mem[m_address] <= m_writedata;
    end

    typedef struct {
        logic [16:0] addr;
        logic        rd;
        logic [7:0]  wd;
        int          cyc;
    } acc_t;
    typedef struct {
        logic [15:0] data;
        int          cyc;
    } rsp_t;

    acc_t acc_q[$];
    rsp_t rsp_q[$];

    int checks   = 0;
    int failures = 0;
    int last_accept;
    logic [15:0] last_rsp_exp = 16'h0000;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Monitor: access sequencing, gap cycles, responses.
    logic        prev_cs_n = 1'b1;
    int          run_len   = 0;
    logic [16:0] cur_addr  = 17'd0;

    always @(negedge clk) begin
        acc_t e;
        rsp_t r;
        if (reset) begin
            prev_cs_n    = 1'b1;
            run_len      = 0;
            last_rsp_exp = 16'h0000;
        end else begin
            if (!m_chipselect_n) begin
                check("be_follows_cs", m_byteenable_n, 1'b0);
                check("one_strobe", m_write_n ^ m_read_n, 1'b1);
                if (prev_cs_n) begin
                    check("acc_expected", acc_q.size() != 0, 1'b1);
                    if (acc_q.size() != 0) begin
                        e = acc_q.pop_front();
                        check("acc_addr", m_address, e.addr);
                        check("acc_write_n", m_write_n, e.rd);
                        check("acc_cycle", cyc, e.cyc);
                        if (!e.rd) check("acc_wdata", m_writedata, e.wd);
                    end
                    run_len  = 1;
                    cur_addr = m_address;
                end else begin
                    run_len++;
                    check("acc_addr_hold", m_address, cur_addr);
                end
            end else if (!prev_cs_n) begin
                check("acc_len", run_len, W + 1);
                check("gap_strobes", {m_byteenable_n, m_write_n, m_read_n}, 3'b111);
                check("gap_addr_hold", m_address, cur_addr);
            end
            if (rsp_valid) begin
                check("rsp_expected", rsp_q.size() != 0, 1'b1);
                if (rsp_q.size() != 0) begin
                    r = rsp_q.pop_front();
                    check("rsp_data", rsp_data, r.data);
                    check("rsp_cycle", cyc, r.cyc);
                    last_rsp_exp = r.data;
                end
            end
            prev_cs_n = m_chipselect_n;
        end
    end

    // Drive a command now (caller guarantees cmd_ready), record expectations.
    task automatic drive_cmd(input logic [1:0] op, input logic [16:0] addr,
                             input logic [16:0] len, input logic [7:0] data);
        int          n;
        int          a;
        logic [15:0] sum;
        logic [16:0] ad;
        acc_t        e;
        rsp_t        r;
        cmd_op    = op;
        cmd_addr  = addr;
        cmd_len   = len;
        cmd_data  = data;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        a           = cyc;
        last_accept = a;
        n   = op[1] ? int'(len) : 1;
        sum = 16'h0000;
        for (int i = 0; i < n; i++) begin
            ad     = addr + 17'(i);
            e.addr = ad;
            e.rd   = op[0];
            e.wd   = data;
            e.cyc  = a + i * (W + 2);
            acc_q.push_back(e);
            if (op[0]) sum = sum + {8'h00, ref_mem[ad]};
            else       ref_mem[ad] = data;
        end
        r.data = op[0] ? sum : 16'h0000;
        r.cyc  = a + n * (W + 2);
        rsp_q.push_back(r);
        $display("TXN op=%0d addr=0x%05h len=%0d data=0x%02h exp_rsp=0x%04h accept_cyc=%0d",
                 op, addr, len, data, r.data, a);
    endtask

    task automatic start_cmd(input logic [1:0] op, input logic [16:0] addr,
                             input logic [16:0] len, input logic [7:0] data);
        int n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("ready_wait", cmd_ready, 1'b1);
        drive_cmd(op, addr, len, data);
    endtask

    task automatic wait_idle();
        int n = 0;
        cmd_valid = 1'b0;
        @(negedge clk);
        while ((acc_q.size() != 0 || rsp_q.size() != 0 || !cmd_ready) && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("idle_rsp_left", rsp_q.size(), 0);
        @(negedge clk);
        check("rsp_hold", rsp_data, last_rsp_exp);
    endtask

    initial begin
        int guard;
        int a1;
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 2'd0;
        cmd_addr  = 17'd0;
        cmd_len   = 17'd0;
        cmd_data  = 8'h00;
        for (int i = 0; i < 131072; i++) begin
            mem[i]     = 8'(i * 7 + 3);
            ref_mem[i] = 8'(i * 7 + 3);
        end
        mem[17'h1FFFE] = 8'hFF; ref_mem[17'h1FFFE] = 8'hFF;
        mem[17'h1FFFF] = 8'hFF; ref_mem[17'h1FFFF] = 8'hFF;
        mem[17'h00000] = 8'hFF; ref_mem[17'h00000] = 8'hFF;
        mem[17'h00001] = 8'hFF; ref_mem[17'h00001] = 8'hFF;

        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_cmd_ready", cmd_ready, 1'b1);
        check("rst_strobes", {m_chipselect_n, m_byteenable_n, m_write_n, m_read_n}, 4'b1111);
        check("rst_address", m_address, 17'd0);
        check("rst_writedata", m_writedata, 8'h00);
        check("rst_rsp", {rsp_valid, rsp_data}, 17'd0);

        // Single write then read back.
        start_cmd(2'd0, 17'h00010, 17'd0, 8'hA5);
        wait_idle();
        check("mem_write", mem[17'h00010], 8'hA5);
        start_cmd(2'd1, 17'h00010, 17'd0, 8'h00);
        wait_idle();
        check("read_result", rsp_data, 16'h00A5);

        // Sum across the address wrap: 4 x 0xFF.
        start_cmd(2'd3, 17'h1FFFE, 17'd4, 8'h00);
        wait_idle();
        check("sum_wrap", rsp_data, 16'h03FC);

        // Fill, then sum and read back the filled range.
        start_cmd(2'd2, 17'h00100, 17'd3, 8'h5A);
        wait_idle();
        start_cmd(2'd3, 17'h00100, 17'd3, 8'h00);
        wait_idle();
        check("fill_sum", rsp_data, 16'h010E);
        start_cmd(2'd1, 17'h00102, 17'd0, 8'h00);
        wait_idle();

        // Zero-length range ops: no bus activity, response next cycle.
        start_cmd(2'd2, 17'h00200, 17'd0, 8'h77);
        wait_idle();
        start_cmd(2'd3, 17'h00200, 17'd0, 8'h00);
        wait_idle();

        // Back-pressure: valid stays high with changing operands while busy.
        start_cmd(2'd1, 17'h00010, 17'd0, 8'h00);
        a1    = last_accept;
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
            if (!cmd_ready) begin
                cmd_op   = 2'($urandom);
                cmd_addr = 17'($urandom);
                cmd_len  = 17'($urandom_range(1, 50));
                cmd_data = 8'($urandom);
            end
        end while (!cmd_ready && guard < 100);
        drive_cmd(2'd0, 17'h00300, 17'd0, 8'h3C);
        check("bp_accept_cycle", last_accept, a1 + W + 4);
        wait_idle();

        // Reset during the second access of an 8-byte sum.
        start_cmd(2'd3, 17'h00300, 17'd8, 8'h00);
        cmd_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("pre_rst_in_access", m_chipselect_n, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        check("rst_mid_strobes", {m_chipselect_n, m_byteenable_n, m_write_n, m_read_n}, 4'b1111);
        check("rst_mid_rsp", {rsp_valid, rsp_data}, 17'd0);
        check("rst_mid_address", m_address, 17'd0);
        acc_q.delete();
        rsp_q.delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_no_rsp", rsp_valid, 1'b0);
        end
        start_cmd(2'd1, 17'h00300, 17'd0, 8'h00);
        wait_idle();
        check("post_rst_read", rsp_data, 16'h003C);

        check("acc_left", acc_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=%0d exp=finished", cyc);
        $fatal(1, "timeout");
    end

endmodule
